// File: rtl/cache_bus1_arbiter_if.sv
// CPU-side C1/A1/D1 bus bundle between two requesters, the arbiter and the cache.
// The slave view belongs to the arbiter; the master view is the requester/cache side.
interface cache_bus1_arbiter_if #(
  parameter int ADDR1_BUS_SIZE = 15,
  parameter int DATA_BUS_SIZE  = 16,
  parameter int CTR1_BUS_SIZE  = 3
);
  logic [CTR1_BUS_SIZE-1:0]  R0_CMD;
  logic [ADDR1_BUS_SIZE-1:0] R0_ADDR;
  logic [DATA_BUS_SIZE-1:0]  R0_DIN;
  logic                      R0_ACK;
  logic                      R0_RESP;
  logic [DATA_BUS_SIZE-1:0]  R0_DOUT;
  logic                      R0_ERR;

  logic [CTR1_BUS_SIZE-1:0]  R1_CMD;
  logic [ADDR1_BUS_SIZE-1:0] R1_ADDR;
  logic [DATA_BUS_SIZE-1:0]  R1_DIN;
  logic                      R1_ACK;
  logic                      R1_RESP;
  logic [DATA_BUS_SIZE-1:0]  R1_DOUT;
  logic                      R1_ERR;

  logic [CTR1_BUS_SIZE-1:0]  CACHE_CMD;
  logic [ADDR1_BUS_SIZE-1:0] CACHE_ADDR;
  logic [DATA_BUS_SIZE-1:0]  CACHE_DOUT;
  logic                      CACHE_RESP;
  logic [DATA_BUS_SIZE-1:0]  CACHE_DIN;

  modport slave (
    input  R0_CMD, R0_ADDR, R0_DIN, R1_CMD, R1_ADDR, R1_DIN, CACHE_RESP, CACHE_DIN,
    output R0_ACK, R0_RESP, R0_DOUT, R0_ERR, R1_ACK, R1_RESP, R1_DOUT, R1_ERR,
           CACHE_CMD, CACHE_ADDR, CACHE_DOUT
  );

  modport master (
    output R0_CMD, R0_ADDR, R0_DIN, R1_CMD, R1_ADDR, R1_DIN, CACHE_RESP, CACHE_DIN,
    input  R0_ACK, R0_RESP, R0_DOUT, R0_ERR, R1_ACK, R1_RESP, R1_DOUT, R1_ERR,
           CACHE_CMD, CACHE_ADDR, CACHE_DOUT
  );
endinterface

// File: rtl/cache_bus1_arbiter.sv
// Round-robin two-requester arbiter for the cache CPU-side bus: two request beats,
// a watchdog-bounded wait, then one (or two for READ32) response beats to the winner.
module cache_bus1_arbiter #(
  parameter int ADDR1_BUS_SIZE = 15,
  parameter int DATA_BUS_SIZE  = 16,
  parameter int CTR1_BUS_SIZE  = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                 CLK,
  input logic                 RESET,
  cache_bus1_arbiter_if.slave bus
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ32 = CTR1_BUS_SIZE'(3);

  typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_BEAT1, S_WAIT, S_DATA1} state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_gnt, w_gnt_nxt;
  logic                     r_last, w_last_nxt;
  logic [CTR1_BUS_SIZE-1:0] r_cmd_q, w_cmd_nxt;
  logic [TW-1:0]            r_timer, w_timer_nxt;

  logic                      w_req0, w_req1;
  logic [ADDR1_BUS_SIZE-1:0] w_addr;
  logic [DATA_BUS_SIZE-1:0]  w_din;
  logic                      w_ack, w_resp, w_err;
  logic [DATA_BUS_SIZE-1:0]  w_dout;

  assign w_req0 = |bus.R0_CMD;
  assign w_req1 = |bus.R1_CMD;
  assign w_addr = r_gnt ? bus.R1_ADDR : bus.R0_ADDR;
  assign w_din  = r_gnt ? bus.R1_DIN  : bus.R0_DIN;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_cmd_q <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_cmd_q <= w_cmd_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_last_nxt     = r_last;
    w_cmd_nxt      = r_cmd_q;
    w_timer_nxt    = r_timer;
    w_ack          = 1'b0;
    w_resp         = 1'b0;
    w_err          = 1'b0;
    w_dout         = '0;
    bus.CACHE_CMD  = '0;
    bus.CACHE_ADDR = '0;
    bus.CACHE_DOUT = '0;

    case (r_state)
      S_IDLE: begin
        if (w_req0 || w_req1) begin
          // On a tie the requester that did not win last time goes first.
          w_gnt_nxt   = (w_req0 && w_req1) ? ~r_last : w_req1;
          w_cmd_nxt   = w_gnt_nxt ? bus.R1_CMD : bus.R0_CMD;
          w_state_nxt = S_BEAT0;
        end
      end
      S_BEAT0: begin
        bus.CACHE_CMD  = r_cmd_q;
        bus.CACHE_ADDR = w_addr;
        bus.CACHE_DOUT = w_din;
        w_ack          = 1'b1;
        w_state_nxt    = S_BEAT1;
      end
      S_BEAT1: begin
        bus.CACHE_ADDR = w_addr;
        bus.CACHE_DOUT = w_din;
        w_timer_nxt    = '0;
        w_state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        w_resp = bus.CACHE_RESP;
        w_dout = bus.CACHE_RESP ? bus.CACHE_DIN : '0;
        if (bus.CACHE_RESP) begin
          if (r_cmd_q == CMD_READ32) begin
            w_state_nxt = S_DATA1;
          end else begin
            w_state_nxt = S_IDLE;
            w_last_nxt  = r_gnt;
          end
        end else if (r_timer == TMAX) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_gnt;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_DATA1: begin
        w_resp      = 1'b1;
        w_dout      = bus.CACHE_DIN;
        w_state_nxt = S_IDLE;
        w_last_nxt  = r_gnt;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.R0_ACK  = w_ack  & ~r_gnt;
  assign bus.R0_RESP = w_resp & ~r_gnt;
  assign bus.R0_ERR  = w_err  & ~r_gnt;
  assign bus.R0_DOUT = r_gnt ? '0 : w_dout;
  assign bus.R1_ACK  = w_ack  & r_gnt;
  assign bus.R1_RESP = w_resp & r_gnt;
  assign bus.R1_ERR  = w_err  & r_gnt;
  assign bus.R1_DOUT = r_gnt ? w_dout : '0;
endmodule

// File: tb/tb_cache_bus1_arbiter.sv
// Directed bench for cache_bus1_arbiter: single requests, ties, WRITE32, READ32,
// watchdog timeout and reset during a pending wait.
module tb_cache_bus1_arbiter;
  logic clk = 1'b0;
  logic rst;
  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  cache_bus1_arbiter_if #(.ADDR1_BUS_SIZE(15), .DATA_BUS_SIZE(16), .CTR1_BUS_SIZE(3)) bus ();

  cache_bus1_arbiter #(
    .ADDR1_BUS_SIZE(15),
    .DATA_BUS_SIZE (16),
    .CTR1_BUS_SIZE (3),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled mid-low-phase.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.R0_CMD = '0; bus.R0_ADDR = '0; bus.R0_DIN = '0;
    bus.R1_CMD = '0; bus.R1_ADDR = '0; bus.R1_DIN = '0;
    bus.CACHE_RESP = 1'b0; bus.CACHE_DIN = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();
    chk("rst_cache_cmd", bus.CACHE_CMD, 0);
    chk("rst_ack0", bus.R0_ACK, 0);
    chk("rst_resp0", bus.R0_RESP, 0);
    chk("rst_state", dut.r_state, 0);

    // Single READ8 from R0
    bus.R0_CMD = 3'd1; bus.R0_ADDR = 15'h1234;
    #1 chk("t1_idle_cmd", bus.CACHE_CMD, 0);
    tick(); #1;
    chk("t1_b0_cmd", bus.CACHE_CMD, 1);
    chk("t1_b0_addr", bus.CACHE_ADDR, 15'h1234);
    chk("t1_b0_ack0", bus.R0_ACK, 1);
    chk("t1_b0_ack1", bus.R1_ACK, 0);
    bus.R0_CMD = '0; bus.R0_ADDR = 15'h5;
    tick(); #1;
    chk("t1_b1_cmd", bus.CACHE_CMD, 0);
    chk("t1_b1_addr", bus.CACHE_ADDR, 15'h5);
    chk("t1_b1_ack0", bus.R0_ACK, 0);
    tick(); #1 chk("t1_w3_resp", bus.R0_RESP, 0);
    tick(); #1 chk("t1_w4_resp", bus.R0_RESP, 0);
    tick();
    bus.CACHE_RESP = 1'b1; bus.CACHE_DIN = 16'h00AB;
    #1;
    chk("t1_resp0", bus.R0_RESP, 1);
    chk("t1_dout0", bus.R0_DOUT, 16'h00AB);
    chk("t1_resp1", bus.R1_RESP, 0);
    tick();
    bus.CACHE_RESP = 1'b0; bus.CACHE_DIN = '0;
    #1;
    chk("t1_back_idle", dut.r_state, 0);
    chk("t1_idle_resp0", bus.R0_RESP, 0);

    // Simultaneous READ16 pairs: R0 first after reset, then R1, then R0 again
    do_reset();
    bus.R0_CMD = 3'd2; bus.R0_ADDR = 15'h0100;
    bus.R1_CMD = 3'd2; bus.R1_ADDR = 15'h0200;
    tick(); #1;
    chk("t2_ack0", bus.R0_ACK, 1);
    chk("t2_ack1_lose", bus.R1_ACK, 0);
    chk("t2_addr0", bus.CACHE_ADDR, 15'h0100);
    bus.R0_CMD = '0;
    tick();
    tick();
    bus.CACHE_RESP = 1'b1; bus.CACHE_DIN = 16'h3344;
    #1;
    chk("t2_resp0", bus.R0_RESP, 1);
    chk("t2_dout0", bus.R0_DOUT, 16'h3344);
    chk("t2_resp1_quiet", bus.R1_RESP, 0);
    chk("t2_dout1_quiet", bus.R1_DOUT, 0);
    tick();
    bus.CACHE_RESP = 1'b0;
    #1 chk("t2_idle_ack1", bus.R1_ACK, 0);
    tick(); #1;
    chk("t2_ack1", bus.R1_ACK, 1);
    chk("t2_ack0_lose", bus.R0_ACK, 0);
    chk("t2_cmd1", bus.CACHE_CMD, 2);
    chk("t2_addr1", bus.CACHE_ADDR, 15'h0200);
    bus.R1_CMD = '0;
    tick();
    tick();
    bus.CACHE_RESP = 1'b1; bus.CACHE_DIN = 16'h5566;
    #1 chk("t2_dout1", bus.R1_DOUT, 16'h5566);
    tick();
    bus.CACHE_RESP = 1'b0;
    bus.R0_CMD = 3'd2; bus.R1_CMD = 3'd2;
    tick(); #1;
    chk("t2_third_ack0", bus.R0_ACK, 1);
    chk("t2_third_ack1", bus.R1_ACK, 0);
    bus.R0_CMD = '0; bus.R1_CMD = '0;
    tick();
    tick();
    bus.CACHE_RESP = 1'b1;
    tick();
    bus.CACHE_RESP = 1'b0;

    // R1 WRITE32 with two data beats
    bus.R1_CMD = 3'd7; bus.R1_ADDR = 15'h0ABC; bus.R1_DIN = 16'hBEEF;
    tick(); #1;
    chk("t3_cmd", bus.CACHE_CMD, 7);
    chk("t3_d_beat0", bus.CACHE_DOUT, 16'hBEEF);
    chk("t3_ack1", bus.R1_ACK, 1);
    bus.R1_CMD = '0; bus.R1_ADDR = 15'h3; bus.R1_DIN = 16'hCAFE;
    tick(); #1;
    chk("t3_d_beat1", bus.CACHE_DOUT, 16'hCAFE);
    chk("t3_b1_cmd", bus.CACHE_CMD, 0);
    tick();
    bus.CACHE_RESP = 1'b1; bus.CACHE_DIN = 16'h0001;
    #1;
    chk("t3_resp1", bus.R1_RESP, 1);
    chk("t3_dout1", bus.R1_DOUT, 16'h0001);
    tick();
    bus.CACHE_RESP = 1'b0; bus.CACHE_DIN = 16'h0F0F;
    #1;
    chk("t3_single_beat", bus.R1_RESP, 0);
    chk("t3_dout_zero", bus.R1_DOUT, 0);

    // R0 READ32 with two response beats
    bus.R0_CMD = 3'd3; bus.R0_ADDR = 15'h0042;
    tick();
    bus.R0_CMD = '0;
    tick();
    tick();
    bus.CACHE_RESP = 1'b1; bus.CACHE_DIN = 16'h1111;
    #1;
    chk("t4_resp_a", bus.R0_RESP, 1);
    chk("t4_dout_a", bus.R0_DOUT, 16'h1111);
    chk("t4_r1_quiet_a", bus.R1_RESP, 0);
    tick();
    bus.CACHE_RESP = 1'b0; bus.CACHE_DIN = 16'h2222;
    #1;
    chk("t4_resp_b", bus.R0_RESP, 1);
    chk("t4_dout_b", bus.R0_DOUT, 16'h2222);
    chk("t4_r1_dout_b", bus.R1_DOUT, 0);
    tick(); #1;
    chk("t4_done", bus.R0_RESP, 0);

    // Watchdog: cache never answers R0, R1 waits and is granted next
    bus.CACHE_DIN = '0;
    bus.R0_CMD = 3'd1; bus.R0_ADDR = 15'h0010;
    tick();
    bus.R0_CMD = '0; bus.R1_CMD = 3'd1; bus.R1_ADDR = 15'h0077;
    #1 chk("t5_ignore_r1", bus.R1_ACK, 0);
    tick();
    tick(); #1 chk("t5_w1_err", bus.R0_ERR, 0);
    tick(); #1 chk("t5_w2_err", bus.R0_ERR, 0);
    tick(); #1 chk("t5_w3_err", bus.R0_ERR, 0);
    tick(); #1;
    chk("t5_w4_err0", bus.R0_ERR, 1);
    chk("t5_w4_err1", bus.R1_ERR, 0);
    chk("t5_w4_resp0", bus.R0_RESP, 0);
    tick(); #1;
    chk("t5_idle_err0", bus.R0_ERR, 0);
    chk("t5_idle_ack1", bus.R1_ACK, 0);
    tick(); #1;
    chk("t5_ack1", bus.R1_ACK, 1);
    chk("t5_addr1", bus.CACHE_ADDR, 15'h0077);
    bus.R1_CMD = '0;
    tick();
    tick();

    // Reset while R1 waits, then a late cache response must be ignored
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.CACHE_RESP = 1'b1; bus.CACHE_DIN = 16'h5555;
    #1;
    chk("t6_state", dut.r_state, 0);
    chk("t6_resp1", bus.R1_RESP, 0);
    chk("t6_dout1", bus.R1_DOUT, 0);
    chk("t6_err1", bus.R1_ERR, 0);
    chk("t6_resp0", bus.R0_RESP, 0);
    bus.R0_CMD = 3'd1; bus.R1_CMD = 3'd1;
    tick();
    bus.CACHE_RESP = 1'b0;
    #1;
    chk("t6_tie_ack0", bus.R0_ACK, 1);
    chk("t6_tie_ack1", bus.R1_ACK, 0);
    clear_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cache_bus1_arbiter.md
Name: cache_bus1_arbiter

Overview:
Two-requester arbiter that shares the cache's CPU-side bus (C1/A1/D1 protocol) between two CPU-side masters. It sits between the requesters and the cache, and uses unidirectional ports on both sides. It sequences each transaction as two request beats followed by a wait, then forwards the response beat(s) back to the winner. Arbitration is round-robin, and a watchdog aborts transactions the cache never answers.

Parameters:
ADDR1_BUS_SIZE, 15, A1 width; carries tag+set on beat0 and offset on beat1.
DATA_BUS_SIZE, 16, D1 width; two bytes per beat, little-endian (byte0 = [7:0]).
CTR1_BUS_SIZE, 3, command width.
TIMEOUT_CYCLES, 256, maximum WAIT cycles before abort; must be >= 2.

Ports:
CLK  in  1  clock; all state changes on posedge.
RESET  in  1  synchronous, active-high reset.
R0_CMD  in  CTR1_BUS_SIZE  requester 0 command: 0 NOP, 1 READ8, 2 READ16, 3 READ32, 4 INVALIDATE_LINE, 5 WRITE8, 6 WRITE16, 7 WRITE32.
R0_ADDR  in  ADDR1_BUS_SIZE  requester 0 address beat.
R0_DIN  in  DATA_BUS_SIZE  requester 0 write data beat.
R0_ACK  out  1  one-cycle pulse in the cycle beat0 is forwarded.
R0_RESP  out  1  response beat valid.
R0_DOUT  out  DATA_BUS_SIZE  response data; 0 when R0_RESP=0.
R0_ERR  out  1  one-cycle timeout pulse.
R1_CMD, R1_ADDR, R1_DIN, R1_ACK, R1_RESP, R1_DOUT, R1_ERR  (same directions and widths)  requester 1.
CACHE_CMD  out  CTR1_BUS_SIZE  command to cache.
CACHE_ADDR  out  ADDR1_BUS_SIZE  address beat to cache.
CACHE_DOUT  out  DATA_BUS_SIZE  write data beat to cache.
CACHE_RESP  in  1  cache C1_RESPONSE indication.
CACHE_DIN  in  DATA_BUS_SIZE  cache read data beat.

Behaviour:
- Registered state:
  - state in {IDLE, BEAT0, BEAT1, WAIT, DATA1}
  - gnt (1 bit), last (1 bit), cmd_q (3 bits)
  - timer (clog2(TIMEOUT_CYCLES) bits)
- Reset (sync, CLK edge with RESET=1): state=IDLE, gnt=0, last=1 (R0 wins the first tie), cmd_q=0, timer=0.
  - RESET overrides every transition, including mid-transaction: abort silently, no RESP or ERR.
- Outputs are combinational from the registered state and the muxed inputs. In IDLE all outputs are 0, and any output not listed for a state is 0.
- IDLE, selection at the edge:
  - If exactly one Rx_CMD != 0: gnt=x.
  - If both: gnt = !last.
  - cmd_q = Rx_CMD of the winner; next state BEAT0.
  - Otherwise stay in IDLE.
- BEAT0 (1 cycle):
  - CACHE_CMD = cmd_q; CACHE_ADDR and CACHE_DOUT = granted ADDR/DIN (tag+set, data bytes 0-1).
  - Rgnt_ACK=1. Next state BEAT1.
- BEAT1 (1 cycle):
  - CACHE_CMD=0; CACHE_ADDR and CACHE_DOUT = granted ADDR/DIN (offset, data bytes 2-3 for WRITE32, don't-care otherwise).
  - Next state WAIT, timer=0.
- WAIT:
  - CACHE_CMD=0; Rgnt_RESP = CACHE_RESP; Rgnt_DOUT = CACHE_DIN when CACHE_RESP=1.
  - On CACHE_RESP=1: if cmd_q==3, go to DATA1; else go to IDLE with last=gnt.
  - Else if timer == TIMEOUT_CYCLES-1: Rgnt_ERR=1 this cycle, go to IDLE with last=gnt.
  - Else timer++.
- DATA1 (1 cycle, READ32 only):
  - Rgnt_RESP=1, Rgnt_DOUT = CACHE_DIN (bytes 2-3) unconditionally; the cache guarantees the second beat.
  - Next state IDLE, last=gnt.
- Requester rules:
  - Hold CMD, ADDR and DIN (beat0) stable until ACK.
  - Present beat1 in the cycle after ACK.
  - Drop CMD to 0 no later than the cycle after ACK.
  - The arbiter ignores both CMD inputs outside IDLE.
- Latency:
  - Request sampled at edge k; BEAT0 occupies cycle k+1.
  - Minimum turnaround is response in cycle k+3 (cache answers in the first WAIT cycle).
  - IDLE always lasts at least one cycle between transactions.
- Fairness: with both requesters always pending, grants strictly alternate, so the worst-case wait is one transaction.
- The cache sees at most one outstanding command; the non-granted requester's outputs stay 0 throughout.

Test Plan:
- Reset then R0_CMD=1 (READ8), R0_ADDR=0x1234 then 0x5 → CACHE_CMD=1 and CACHE_ADDR=0x1234 in cycle 1 with R0_ACK=1; CACHE_CMD=0 and CACHE_ADDR=0x5 in cycle 2; CACHE_RESP=1 with DIN=0x00AB in cycle 5 → R0_RESP=1, R0_DOUT=0x00AB in cycle 5; state returns to IDLE.
- R0 and R1 both issue READ16 in the same cycle after reset → R0 is granted first; R1_ACK pulses in the BEAT0 after R0's response completes; a third simultaneous pair is granted to R0 again.
- R1 WRITE32, DIN 0xBEEF then 0xCAFE → CACHE_DOUT=0xBEEF in BEAT0 and 0xCAFE in BEAT1; R1_RESP is a single beat with R1_DOUT=CACHE_DIN.
- R0 READ32, cache answers 0x1111 then 0x2222 on consecutive cycles → R0_RESP high for 2 cycles with DOUT 0x1111 then 0x2222; R1 outputs stay 0.
- TIMEOUT_CYCLES=4, cache never responds → R0_ERR pulses in the 4th WAIT cycle; next IDLE grants a pending R1.
- RESET asserted during WAIT, then CACHE_RESP=1 → no RESP or ERR; state is IDLE with last=1.
